// File: rtl/segment_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered frame load.
// Optional build macro LZ_BLANK_EN enables leading-zero suppression.
module segment_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_en,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  output logic [3:0]              digit_data,
  output logic                    digit_dp,
  output logic [NUM_DIGITS-1:0]   select,
  output logic [IW-1:0]           digit_idx,
  output logic                    frame_done
);

  localparam int unsigned MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned PW   = $clog2(MAXC + 1);

  typedef enum logic {BLANK, SHOW} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                    pend_q, pend_d;
  logic [3:0]              digit_data_q, digit_data_d;
  logic                    digit_dp_q, digit_dp_d;
  logic [NUM_DIGITS-1:0]   select_q, select_d;
  logic                    frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0]   lz_sup;

  logic blank_end, show_end, last_digit, boundary, xfer;

`ifdef LZ_BLANK_EN
  // Digit i is dark when it and every more significant nibble are zero.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_sup   = '0;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      zero_run = zero_run & (act_data_q[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      if (NUM_DIGITS-1-j > 0) lz_sup[NUM_DIGITS-1-j] = zero_run;
    end
  end
`else
  assign lz_sup = '0;
`endif

  assign blank_end  = (state_q == BLANK) && (phase_q == PW'(BLANK_CYCLES - 1));
  assign show_end   = (state_q == SHOW)  && (phase_q == PW'(DWELL_CYCLES - 1));
  assign last_digit = (idx_q == IW'(NUM_DIGITS - 1));
  assign boundary   = show_end && last_digit;
  assign xfer       = load_valid && !pend_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q + PW'(1);
    idx_d        = idx_q;
    act_data_d   = act_data_q;
    act_en_d     = act_en_q;
    act_dp_d     = act_dp_q;
    pend_data_d  = pend_data_q;
    pend_en_d    = pend_en_q;
    pend_dp_d    = pend_dp_q;
    pend_d       = pend_q;
    digit_data_d = digit_data_q;
    digit_dp_d   = digit_dp_q;
    select_d     = '0;

    unique case (state_q)
      BLANK: begin
        if (blank_end) begin
          state_d = SHOW;
          phase_d = '0;
        end
      end
      SHOW: begin
        if (show_end) begin
          state_d = BLANK;
          phase_d = '0;
          idx_d   = last_digit ? '0 : idx_q + IW'(1);
        end
      end
      default: state_d = BLANK;
    endcase

    if (boundary && pend_q) begin
      act_data_d = pend_data_q;
      act_en_d   = pend_en_q;
      act_dp_d   = pend_dp_q;
      pend_d     = 1'b0;
    end

    // xfer implies pend_q=0, so it never collides with the copy-out above.
    if (xfer) begin
      pend_data_d = load_data;
      pend_en_d   = load_en;
      pend_dp_d   = load_dp;
      pend_d      = 1'b1;
    end

    // Entering BLANK presents the next digit early, using the post-boundary frame.
    if (show_end) begin
      digit_data_d = act_data_d[{idx_d, 2'b00} +: 4];
      digit_dp_d   = act_dp_d[idx_d];
    end

    if (state_d == SHOW) select_d[idx_d] = act_en_q[idx_d] & ~lz_sup[idx_d];

    frame_done_d = (state_d == SHOW) && (phase_d == PW'(DWELL_CYCLES - 1))
                   && (idx_d == IW'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      phase_q      <= '0;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_en_q     <= '0;
      act_dp_q     <= '0;
      pend_data_q  <= '0;
      pend_en_q    <= '0;
      pend_dp_q    <= '0;
      pend_q       <= 1'b0;
      digit_data_q <= '0;
      digit_dp_q   <= 1'b0;
      select_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_en_q     <= act_en_d;
      act_dp_q     <= act_dp_d;
      pend_data_q  <= pend_data_d;
      pend_en_q    <= pend_en_d;
      pend_dp_q    <= pend_dp_d;
      pend_q       <= pend_d;
      digit_data_q <= digit_data_d;
      digit_dp_q   <= digit_dp_d;
      select_q     <= select_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = ~pend_q;
  assign digit_data = digit_data_q;
  assign digit_dp   = digit_dp_q;
  assign select     = select_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_segment_scan_ctrl.sv
// Scoreboard bench for segment_scan_ctrl: a timeline model predicts every output
// cycle from elapsed cycles since reset and the frame hand-over rules.
module tb_segment_scan_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 4;
  localparam int unsigned BL = 2;
  localparam int unsigned SLOT  = DW + BL;
  localparam int unsigned FRAME = N * SLOT;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [4*N-1:0] load_data;
  logic [N-1:0]  load_en;
  logic [N-1:0]  load_dp;
  logic [3:0]    digit_data;
  logic          digit_dp;
  logic [N-1:0]  select;
  logic [2:0]    digit_idx;
  logic          frame_done;

  segment_scan_ctrl #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_en   (load_en),
    .load_dp   (load_dp),
    .digit_data(digit_data),
    .digit_dp  (digit_dp),
    .select    (select),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned t;
    logic [N-1:0] sel;
    logic [3:0]   data;
    logic         dp;
    logic [2:0]   idx;
    logic         fd;
    logic         rdy;
  } exp_t;

  exp_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state: the displayed frame and the one waiting for a boundary.
  bit            started = 0;
  int unsigned   t = 0;
  bit            m_pend = 0;
  logic [4*N-1:0] m_act_data = '0, m_pend_data = '0;
  logic [N-1:0]  m_act_en = '0, m_act_dp = '0, m_pend_en = '0, m_pend_dp = '0;

  task automatic model_step();
    bit old_pend;
    int unsigned pos, slot;
    bit sup;
    exp_t e;
    if (rst) begin
      started = 1; t = 0; m_pend = 0;
      m_act_data = '0; m_act_en = '0; m_act_dp = '0;
    end else if (started) begin
      old_pend = m_pend;
      if ((t % FRAME == FRAME - 1) && old_pend) begin
        m_act_data = m_pend_data; m_act_en = m_pend_en; m_act_dp = m_pend_dp;
        m_pend = 0;
      end
      if (load_valid && !old_pend) begin
        m_pend_data = load_data; m_pend_en = load_en; m_pend_dp = load_dp;
        m_pend = 1;
      end
      t++;
    end
    if (started) begin
      pos  = t % SLOT;
      slot = (t / SLOT) % N;
      sup  = 0;
`ifdef LZ_BLANK_EN
      if (slot > 0) begin
        sup = 1;
        for (int unsigned k = slot; k < N; k++)
          if (m_act_data[4*k +: 4] != 4'h0) sup = 0;
      end
`endif
      e.t    = t;
      e.sel  = (pos >= BL && m_act_en[slot] && !sup) ? (N'(1) << slot) : '0;
      e.data = m_act_data[4*slot +: 4];
      e.dp   = m_act_dp[slot];
      e.idx  = 3'(slot);
      e.fd   = (t % FRAME == FRAME - 1);
      e.rdy  = !m_pend;
      q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic chk(input string name, input int unsigned tt,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, tt, act, exp);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("select",     e.t, 32'(select),     32'(e.sel));
      chk("digit_data", e.t, 32'(digit_data), 32'(e.data));
      chk("digit_dp",   e.t, 32'(digit_dp),   32'(e.dp));
      chk("digit_idx",  e.t, 32'(digit_idx),  32'(e.idx));
      chk("frame_done", e.t, 32'(frame_done), 32'(e.fd));
      chk("load_ready", e.t, 32'(load_ready), 32'(e.rdy));
    end
  end

  task automatic run(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [4*N-1:0] d, input logic [N-1:0] en,
                       input logic [N-1:0] dp);
    bit ok;
    ok = 0;
    load_data = d; load_en = en; load_dp = dp; load_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (load_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    load_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL offer_timeout data=%h got=not_accepted expected=accepted", d);
    end
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0; load_en = '0; load_dp = '0;
    run(3);
    rst = 1'b0;
    run(10);

    offer(32'h7654_3210, 8'hFF, 8'h01);
    run(100);
    offer(32'h89AB_CDEF, 8'b1000_0010, 8'hF0);
    run(100);

    // Back-to-back frames: B must wait for the boundary that applies A.
    offer(32'h1111_1111, 8'hFF, 8'h00);
    offer(32'h2222_2222, 8'hFF, 8'hFF);
    run(130);

    // Offer on the exact frame_done cycle with nothing pending.
    for (int i = 0; i < 100; i++) begin
      if (t % FRAME == FRAME - 1) break;
      run(1);
    end
    load_data = 32'hC0C0_C0C0; load_en = 8'h5A; load_dp = 8'h0F; load_valid = 1'b1;
    run(1);
    load_valid = 1'b0;
    run(110);

    offer(32'h0000_0305, 8'hFF, 8'h00);
    run(110);

    for (int i = 0; i < 400; i++) begin
      load_valid = ($urandom % 4 == 0);
      load_data  = $urandom;
      load_en    = 8'($urandom);
      load_dp    = 8'($urandom);
      run(1);
    end
    load_valid = 1'b0;
    run(20);

    // Mid-scan reset with a frame offered; it must be discarded.
    rst = 1'b1; load_valid = 1'b1; load_data = 32'hDEAD_BEEF; load_en = 8'hFF;
    run(3);
    rst = 1'b0; load_valid = 1'b0;
    run(60);

    for (int i = 0; i < 200; i++) begin
      load_valid = ($urandom % 3 == 0);
      load_data  = $urandom;
      load_en    = 8'($urandom);
      load_dp    = 8'($urandom);
      run(1);
    end
    load_valid = 1'b0;
    run(5);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
